// File: rtl/mdu_multicycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mdu_multicycle                                               |
// | Description : Multi-cycle multiply/divide unit owning the HI/LO registers. |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mdu_multicycle #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MDOp,
    input  logic        Flush,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic        Busy
);

    localparam logic [0:0] c_st_idle = 1'b0;
    localparam logic [0:0] c_st_run  = 1'b1;

    localparam logic [2:0] c_op_mult  = 3'd1;
    localparam logic [2:0] c_op_multu = 3'd2;
    localparam logic [2:0] c_op_div   = 3'd3;
    localparam logic [2:0] c_op_divu  = 3'd4;
    localparam logic [2:0] c_op_mthi  = 3'd5;
    localparam logic [2:0] c_op_mtlo  = 3'd6;

    localparam logic [3:0] c_mult_cnt = 4'(MULT_CYCLES);
    localparam logic [3:0] c_div_cnt  = 4'(DIV_CYCLES);

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_busy;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;
    logic        r_pend_wr;

    logic        w_issue;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_dvd;
    logic [31:0] w_dvs;
    logic [31:0] w_quot;
    logic [31:0] w_rem;
    logic [31:0] w_div_hi;
    logic [31:0] w_div_lo;

    assign w_issue = Start && !Flush && (r_state == c_st_idle);

    assign w_prod_s = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide runs on magnitudes so the most-negative dividend cannot overflow.
    assign w_a_neg  = (MDOp == c_op_div) && A[31];
    assign w_b_neg  = (MDOp == c_op_div) && B[31];
    assign w_dvd    = w_a_neg ? (~A + 32'd1) : A;
    assign w_dvs    = (B == 32'd0) ? 32'd1 : (w_b_neg ? (~B + 32'd1) : B);
    assign w_quot   = w_dvd / w_dvs;
    assign w_rem    = w_dvd % w_dvs;
    assign w_div_lo = (w_a_neg ^ w_b_neg) ? (~w_quot + 32'd1) : w_quot;
    assign w_div_hi = w_a_neg ? (~w_rem + 32'd1) : w_rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= c_st_idle;
            r_cnt     <= 4'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_busy    <= 1'b0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_issue) begin
                        case (MDOp)
                            c_op_mult, c_op_multu: begin
                                r_pend_hi <= (MDOp == c_op_mult) ? w_prod_s[63:32] : w_prod_u[63:32];
                                r_pend_lo <= (MDOp == c_op_mult) ? w_prod_s[31:0]  : w_prod_u[31:0];
                                r_pend_wr <= 1'b1;
                                r_cnt     <= c_mult_cnt;
                                r_busy    <= 1'b1;
                                r_state   <= c_st_run;
                            end
                            c_op_div, c_op_divu: begin
                                r_pend_hi <= w_div_hi;
                                r_pend_lo <= w_div_lo;
                                // Divide by zero still occupies the unit but never commits.
                                r_pend_wr <= (B != 32'd0);
                                r_cnt     <= c_div_cnt;
                                r_busy    <= 1'b1;
                                r_state   <= c_st_run;
                            end
                            c_op_mthi: r_hi <= A;
                            c_op_mtlo: r_lo <= A;
                            default: ;
                        endcase
                    end
                end
                c_st_run: begin
                    if (r_cnt == 4'd1) begin
                        if (r_pend_wr) begin
                            r_hi <= r_pend_hi;
                            r_lo <= r_pend_lo;
                        end
                        r_pend_wr <= 1'b0;
                        r_cnt     <= 4'd0;
                        r_busy    <= 1'b0;
                        r_state   <= c_st_idle;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign HI   = r_hi;
    assign LO   = r_lo;
    assign Busy = r_busy;

endmodule
`default_nettype wire

// File: doc/mdu_multicycle.md
Name: mdu_multicycle

Overview:
- Multi-cycle multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Executes mult, multu, div and divu, which the single-cycle ALU cannot do in one cycle.
- Owns the HI/LO registers and executes mthi/mtlo.
- Raises Busy so the hazard unit stalls mfhi/mflo and further MDU instructions.

Parameters:
- MULT_CYCLES, 5, number of cycles Busy stays high for mult/multu (legal range 1..15).
- DIV_CYCLES, 10, number of cycles Busy stays high for div/divu (legal range 1..15).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- Start  input  1  strobe qualifying MDOp for one cycle.
- MDOp  input  3  operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- Flush  input  1  exception/eret flush of the EX instruction; suppresses the op issued in the same cycle.
- A  input  32  rs operand (multiplicand / dividend / mthi-mtlo source).
- B  input  32  rt operand (multiplier / divisor).
- HI  output  32  HI register.
- LO  output  32  LO register.
- Busy  output  1  high while a mult/div is in flight.

Behaviour:
- Reset (edge with reset=1): HI=0, LO=0, Busy=0, cycle counter=0, pending result discarded. Reset has priority over every other input.
- Reset mid-operation aborts the operation. No HI/LO write occurs afterwards.
- An op issues on an edge only when Start=1, Flush=0 and Busy=0. All other Start cycles are ignored with no state change.
- States: IDLE and RUN.
- IDLE to RUN: a mult/multu/div/divu op issues.
  - The result is computed from A/B sampled at that edge and held in pending_hi/pending_lo.
  - The counter loads MULT_CYCLES or DIV_CYCLES.
- RUN: the counter decrements every edge. Busy=1 throughout RUN.
- RUN to IDLE: on the edge where the counter equals 1, HI/LO are written from pending and Busy drops.
- Timing: issue at edge t0, so Busy=1 during cycles t0+1 .. t0+N. New HI/LO and Busy=0 are both visible from t0+N+1. HI/LO hold their old values while Busy=1.
- mthi/mtlo (op 5/6) from IDLE:
  - Single cycle: HI (or LO) = A on the issuing edge.
  - Busy stays 0; the other register is unchanged.
- mthi/mtlo while Busy=1 are ignored; the hazard unit guarantees they stall.
- Arithmetic rules:
  - mult: signed 32x32 to 64-bit, HI=[63:32], LO=[31:0].
  - multu: unsigned, same split.
  - div: signed, quotient truncates toward zero to LO; remainder takes the sign of the dividend to HI.
  - 0x80000000 div 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned, LO=quotient, HI=remainder.
- Divide by zero (B=0, div or divu):
  - Busy still runs DIV_CYCLES.
  - HI/LO keep their pre-issue values; no write at completion.
- Flush=1 together with Start suppresses the issue entirely, including mthi/mtlo.
- Flush while Busy=1 has no effect; the in-flight op commits.
- Outputs HI, LO and Busy are registered; no combinational path from inputs.

Test Plan:
- Reset, then Start with MDOp=1, A=0xFFFFFFFE (-2), B=3:
  - Busy=1 for exactly 5 cycles.
  - Next cycle HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - HI/LO read 0 while busy.
- MDOp=2, A=0xFFFFFFFF, B=2:
  - HI=0x00000001, LO=0xFFFFFFFE after 5 busy cycles.
  - A second Start issued in busy cycle 2 is ignored; Busy still ends after cycle 5.
- MDOp=3, A=0xFFFFFFF9 (-7), B=2:
  - Busy for 10 cycles.
  - Then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- MDOp=4, A=7, B=2: LO=3, HI=1.
  - Then MDOp=3, A=5, B=0: Busy runs 10 cycles, and HI=1, LO=3 are unchanged afterwards.
- MDOp=5, A=0x12345678, then MDOp=6, A=0x9ABCDEF0:
  - HI and LO update on their respective issue edges.
  - Busy never rises.
  - The same MDOp=5 issue with Flush=1 leaves HI unchanged.
- Start mult, assert reset in busy cycle 3:
  - Next cycle HI=LO=0, Busy=0.
  - No late HI/LO write at what would have been cycle 6.
